// File: rtl/bram_arb_pkg.sv
// Shared constants and elaboration helpers for the block-RAM round-robin arbiter.
package bram_arb_pkg;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit id_bits_ok(input int num_req, input int id_bits);
    return (num_req >= 2) && (num_req <= 8) && (id_bits == clog2(num_req));
  endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Latency: purely combinational. Backpressure: none, grant follows req directly.
// Output is one-hot or all-zero; any flags a grant.
module rr_pick
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_BITS-1:0] gidx,
  output logic               any
);

  logic [ID_BITS-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_BITS'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin share of one registered-read block RAM among NUM_REQ clients.
// Latency: read data 1 cycle after grant (2 with BRAM_ARB_RSP_REG_EN); writes land same cycle.
// Backpressure: req_ready one-hot grant per cycle; responses have no backpressure.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_BITS = 4,
  parameter int ID_BITS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [ID_BITS-1:0]             rsp_id,
  output logic [RAM_WIDTH-1:0]           rsp_data,
  output logic                           ram_w_en,
  output logic [ADDR_BITS-1:0]           ram_w_addr,
  output logic [ADDR_BITS-1:0]           ram_r_addr,
  output logic [RAM_WIDTH-1:0]           ram_wdata,
  input  logic [RAM_WIDTH-1:0]           ram_rdata
);

  if (!id_bits_ok(NUM_REQ, ID_BITS)) begin : g_bad_cfg
    $error("bram_rr_arbiter: ID_BITS must equal clog2(NUM_REQ), NUM_REQ in 2..8");
  end

  logic [ADDR_BITS-1:0] addr_arr  [NUM_REQ];
  logic [RAM_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_BITS +: ADDR_BITS];
    assign wdata_arr[i] = req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
  end

  logic [NUM_REQ-1:0]   pick_req;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_BITS-1:0]   gidx;
  logic                 any;
  logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_BITS-1:0] w_addr_q, r_addr_q;
  logic [RAM_WIDTH-1:0] wdata_q;
  logic                 wr_grant, rd_grant;
  logic                 rsp_vld_q;
  logic [ID_BITS-1:0]   rsp_id_q;

  // Masking requests in reset keeps req_ready low and the pointer untouched.
  assign pick_req = rst ? '0 : req_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  assign req_ready = grant;
  assign wr_grant  = any && (req_we[gidx] == REQ_WR);
  assign rd_grant  = any && (req_we[gidx] == REQ_RD);

  assign ram_w_en   = wr_grant;
  assign ram_w_addr = wr_grant ? addr_arr[gidx]  : w_addr_q;
  assign ram_wdata  = wr_grant ? wdata_arr[gidx] : wdata_q;
  assign ram_r_addr = rd_grant ? addr_arr[gidx]  : r_addr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any) begin
      rr_ptr_d = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      w_addr_q  <= '0;
      r_addr_q  <= '0;
      wdata_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      w_addr_q  <= ram_w_addr;
      r_addr_q  <= ram_r_addr;
      wdata_q   <= ram_wdata;
      rsp_vld_q <= rd_grant;
      if (rd_grant) rsp_id_q <= gidx;
    end
  end

`ifdef BRAM_ARB_RSP_REG_EN
  logic                 rsp2_vld_q;
  logic [ID_BITS-1:0]   rsp2_id_q;
  logic [RAM_WIDTH-1:0] rsp2_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp2_vld_q  <= 1'b0;
      rsp2_id_q   <= '0;
      rsp2_data_q <= '0;
    end else begin
      rsp2_vld_q  <= rsp_vld_q;
      rsp2_id_q   <= rsp_id_q;
      rsp2_data_q <= ram_rdata;
    end
  end

  assign rsp_valid = rsp2_vld_q;
  assign rsp_id    = rsp2_id_q;
  assign rsp_data  = rsp2_data_q;
`else
  // RAM output register already aligns with the read issued last cycle.
  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_rdata;
`endif

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a behavioural registered-read block RAM.
module tb_bram_rr_arbiter;

`ifdef BRAM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        ram_w_en;
  logic [3:0]  ram_w_addr, ram_r_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  mem [16] = '{default: 8'h00};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_wdata;
    ram_rdata <= mem[ram_r_addr];
  end

  bram_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_r_addr (ram_r_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'hF; req_we = 4'h0; req_addr = 16'h0; req_wdata = 32'h0;
    tick; tick;
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    n_tests++; if (ram_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en got %b want 0", ram_w_en); end
    n_tests++; if (ram_r_addr !== 4'd0) begin n_fail++; $display("FAIL reset_r_addr got %0d want 0", ram_r_addr); end
    n_tests++; if (ram_w_addr !== 4'd0) begin n_fail++; $display("FAIL reset_w_addr got %0d want 0", ram_w_addr); end
    n_tests++; if (ram_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got %h want 00", ram_wdata); end
    req_valid = 4'h0; rst = 1'b0;
    tick;
  endtask

  task automatic test_write_read;
    req_valid = 4'b0001; req_we = 4'b0001; req_addr = 16'h0003; req_wdata = 32'h0000_00A5;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wr_ready got %b want 0001", req_ready); end
    n_tests++; if (ram_w_en !== 1'b1) begin n_fail++; $display("FAIL wr_w_en got %b want 1", ram_w_en); end
    n_tests++; if (ram_w_addr !== 4'd3) begin n_fail++; $display("FAIL wr_w_addr got %0d want 3", ram_w_addr); end
    n_tests++; if (ram_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_wdata got %h want a5", ram_wdata); end
    tick;
    req_we = 4'b0000;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rd_ready got %b want 0001", req_ready); end
    n_tests++; if (ram_w_en !== 1'b0) begin n_fail++; $display("FAIL rd_w_en got %b want 0", ram_w_en); end
    n_tests++; if (ram_r_addr !== 4'd3) begin n_fail++; $display("FAIL rd_r_addr got %0d want 3", ram_r_addr); end
    n_tests++; if (ram_w_addr !== 4'd3) begin n_fail++; $display("FAIL rd_w_addr_hold got %0d want 3", ram_w_addr); end
    tick;
    req_valid = 4'b0000;
    for (int c = 1; c < LAT; c++) begin
      #1;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid got %b want 0", rsp_valid); end
      tick;
    end
    #1;
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid got %b want 1", rsp_valid); end
    n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rd_rsp_id got %0d want 0", rsp_id); end
    n_tests++; if (rsp_data !== 8'hA5) begin n_fail++; $display("FAIL rd_rsp_data got %h want a5", rsp_data); end
    tick;
    #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_extra_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    logic [7:0] exp_dat;
    rst = 1'b1; req_valid = 4'h0;
    tick;
    rst = 1'b0;
    for (int j = 0; j <= 7 + LAT; j++) begin
      req_valid = (j < 8) ? 4'hF : 4'h0;
      req_we    = 4'h0;
      req_addr  = 16'h3210;
      #1;
      if (j < 8) begin
        exp_rdy = 4'(1 << (j % 4));
        n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", j, req_ready, exp_rdy); end
        n_tests++; if (ram_r_addr !== 4'(j % 4)) begin n_fail++; $display("FAIL rr_r_addr[%0d] got %0d want %0d", j, ram_r_addr, j % 4); end
      end
      if (j < LAT) begin
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle_valid[%0d] got %b want 0", j, rsp_valid); end
      end else begin
        exp_id  = 2'((j - LAT) % 4);
        exp_dat = (exp_id == 2'd3) ? 8'hA5 : 8'h00;
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_valid[%0d] got %b want 1", j, rsp_valid); end
        n_tests++; if (rsp_id !== exp_id) begin n_fail++; $display("FAIL rr_rsp_id[%0d] got %0d want %0d", j, rsp_id, exp_id); end
        n_tests++; if (rsp_data !== exp_dat) begin n_fail++; $display("FAIL rr_rsp_data[%0d] got %h want %h", j, rsp_data, exp_dat); end
      end
      tick;
    end
  endtask

  task automatic test_sole_requester;
    req_valid = 4'b0100; req_we = 4'h0; req_addr = 16'h0200;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL sole_ready[%0d] got %b want 0100", k, req_ready); end
      tick;
    end
    req_valid = 4'hF;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL sole_next_ptr got %b want 1000", req_ready); end
    tick;
    req_valid = 4'h0;
    repeat (LAT + 1) tick;
  endtask

  task automatic test_wr_then_rd_wrap;
    req_valid = 4'b0010; req_we = 4'b0010; req_addr = 16'h00F0; req_wdata = 32'h0000_3C00;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_wr_ready got %b want 0010", req_ready); end
    n_tests++; if (ram_w_en !== 1'b1) begin n_fail++; $display("FAIL wrap_w_en got %b want 1", ram_w_en); end
    n_tests++; if (ram_w_addr !== 4'hF) begin n_fail++; $display("FAIL wrap_w_addr got %0d want 15", ram_w_addr); end
    n_tests++; if (ram_wdata !== 8'h3C) begin n_fail++; $display("FAIL wrap_wdata got %h want 3c", ram_wdata); end
    tick;
    req_valid = 4'b1000; req_we = 4'h0; req_addr = 16'hF000;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_rd_ready got %b want 1000", req_ready); end
    n_tests++; if (ram_r_addr !== 4'hF) begin n_fail++; $display("FAIL wrap_r_addr got %0d want 15", ram_r_addr); end
    n_tests++; if (ram_w_en !== 1'b0) begin n_fail++; $display("FAIL wrap_rd_w_en got %b want 0", ram_w_en); end
    tick;
    req_valid = 4'h0;
    for (int c = 1; c < LAT; c++) tick;
    #1;
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_rsp_valid got %b want 1", rsp_valid); end
    n_tests++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_rsp_id got %0d want 3", rsp_id); end
    n_tests++; if (rsp_data !== 8'h3C) begin n_fail++; $display("FAIL wrap_rsp_data got %h want 3c", rsp_data); end
    tick;
  endtask

  task automatic test_reset_mid;
    req_valid = 4'b0010; req_we = 4'h0; req_addr = 16'h0030;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rstmid_grant got %b want 0010", req_ready); end
    tick;
    rst = 1'b1; req_valid = 4'hF;
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ready got %b want 0000", req_ready); end
    tick;
    #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_valid got %b want 0", rsp_valid); end
    n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_rsp_id got %0d want 0", rsp_id); end
    rst = 1'b0;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr got %b want 0001", req_ready); end
    tick;
    req_valid = 4'h0;
    repeat (LAT + 1) tick;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_round_robin;
    test_sole_requester;
    test_wr_then_rd_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
